inner_product: RTL and testbench
================================

Name: inner_product

Overview:
Parametrised successor to the single-neuron inner-product datapath. It collects N signed arguments in any order over per-channel stb/rdy handshakes and holds N+1 weights (N taps plus bias) in a runtime-writable register file. Once all arguments are in, it runs a sequential multiply-accumulate, one term per cycle, and emits the biased dot product on a single stb/rdy master. It sits between the argument fabric and the activation stage of a neuron.

Parameters:
W, 8, argument/weight width (signed two's complement)
N, 4, number of argument channels (>=1)
F, 4, fractional bits of arguments and weights; result carries 2F fractional bits

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
s_stb  input  N  per-channel argument strobe
s_dat  input  N*W  argument data, channel i at [i*W+:W]
s_rdy  output  N  per-channel argument ready
w_stb  input  1  weight write strobe
w_adr  input  $clog2(N+1)  weight index; N = bias
w_dat  input  W  weight value
w_rdy  output  1  weight write ready
m_rdy  input  1  result ready
m_stb  output  1  result strobe
m_dat  output  2*W  result, signed, 2F fractional bits

Behaviour:
- One clock. Reset is asynchronous and active-low. All state is reset by rst low, independent of clk.
- Reset values:
  - state COLLECT, captured[] = 0, weights = 0, accumulator = 0, index = 0.
  - Outputs: m_stb = 0, m_dat = 0, s_rdy = all ones, w_rdy = 1.
- State COLLECT:
  - s_rdy[i] = ~captured[i].
  - Handshake on channel i (s_stb[i] & s_rdy[i]) latches x[i] and sets captured[i].
  - Channels complete independently and in any order. Several channels may complete in the same cycle.
  - w_rdy = 1. A weight handshake writes w[w_adr] = w_dat. An address > N is accepted and discarded.
  - An argument handshake and a weight handshake in the same cycle are both accepted.
  - When every captured bit is set (including bits set in the current cycle), go to MAC. The accumulator loads sign-extended w[N] << F, and index loads 0.
- State MAC:
  - s_rdy = 0 and w_rdy = 0, so weights are stable during computation.
  - Each cycle: acc += sext(w[index]) * sext(x[index]); index++.
  - After index N-1 is processed, go to OUT.
- Accumulator width is A = 2W + $clog2(N+1). It never overflows internally.
- State OUT:
  - m_stb = 1 and m_dat = conv(acc); both are held stable until m_rdy.
  - On m_stb & m_rdy: clear captured[], return to COLLECT. s_rdy reasserts the following cycle.
- Latency: with the last argument accepted at cycle t, MAC runs cycles t+1..t+N and m_stb rises at t+N+1.
- Throughput: one result per N+2 cycles plus the argument collection time.
- Backpressure: while m_rdy is low the block stays in OUT indefinitely. No arguments or weight writes are accepted.
- Reset mid-operation (any state): all work is abandoned, weights are zeroed, and outputs return to their reset values.

Optional Feature:
- Macro INNER_PRODUCT_SATURATE_EN.
- Defined: conv(acc) saturates to the signed 2W range. Above 2^(2W-1)-1 gives 0x7F..F; below -2^(2W-1) gives 0x80..0.
- Undefined: conv(acc) = acc[2W-1:0], i.e. two's-complement wrap.

Decomposition:
- Shared package holds:
  - State enum {COLLECT, MAC, OUT}.
  - Function acc_width(W,N) = 2W+$clog2(N+1).
  - Function sat2w(acc) used by conv.
- One natural sub-module: inner_weights.
  - (N+1)xW register file, async active-low reset to zero.
  - One write port gated by w_rdy, one combinational read port indexed by the MAC index or by N for the bias.

Test Plan:
- Nominal dot product (W=8, N=4, F=4): write w[0..4]=16. Send args 16,32,48,-16 (1,2,3,-1) -> m_dat=0x0600 (6.0), m_stb at t+5.
- Out-of-order, sparse arrival: same weights, args presented on channels 3,1,0,2 with idle gaps and s_stb held before rdy -> each s_rdy[i] drops after its handshake; m_dat=0x0600.
- Overflow: all weights 127, all args 127 -> 0x7FFF with INNER_PRODUCT_SATURATE_EN, 0x03F4 without.
- Backpressure and weight lock: hold m_rdy=0 for 5 cycles, assert w_stb with w_adr=0 during MAC and OUT -> m_stb/m_dat stable, s_rdy=0, w_rdy=0; the write is accepted only on the first COLLECT cycle and affects the next result only.
- Invalid address: w_stb with w_adr=7 and w_dat=99 -> handshake completes, no weight changes, next result unchanged.
- Reset mid-MAC: pull rst low asynchronously for 1 cycle during MAC -> m_stb=0 immediately, s_rdy=all ones, w_rdy=1. Fresh args with no weight writes -> m_dat=0x0000.

Source files
------------

// File: rtl/inner_product_pkg.sv
// Shared types and helpers for the inner_product neuron datapath:
// FSM state encoding, accumulator sizing and 2W-bit saturation.
package inner_product_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MAC     = 2'd1,
    OUT     = 2'd2
  } state_t;

  // Width that holds N signed WxW products plus a shifted bias without overflow.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n + 1);
  endfunction

  // Clamp a sign-extended accumulator into the signed w2-bit range.
  function automatic longint sat2w(input longint acc, input int w2);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w2 - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/inner_weights.sv
// (N+1)xW weight register file: N taps plus bias at index N.
// One gated write port; combinational tap read by MAC index and a dedicated bias read.
module inner_weights
  import inner_product_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int AW = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [AW-1:0]       i_adr,
  input  logic signed [W-1:0] i_dat,
  input  logic [AW-1:0]       i_radr,
  output logic signed [W-1:0] o_rdat,
  output logic signed [W-1:0] o_bias
);

  logic signed [W-1:0] r_w [N+1];

  // NOTE: this array is reset explicitly because weights must read as zero after any reset;
  // storage without that guarantee would normally be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= N; i++) r_w[i] <= '0;
    end else begin
      // Addresses above N match no entry and are silently dropped.
      for (int i = 0; i <= N; i++) begin
        if (i_we && i_adr == AW'(i)) r_w[i] <= i_dat;
      end
    end
  end

  // NOTE: default assigned first so the mux never infers a latch.
  always_comb begin
    o_rdat = '0;
    for (int i = 0; i < N; i++) begin
      if (i_radr == AW'(i)) o_rdat = r_w[i];
    end
  end

  assign o_bias = r_w[N];

endmodule

// File: rtl/inner_product.sv
// Biased dot product of N handshaked signed arguments with runtime-writable weights,
// one MAC term per cycle. Define INNER_PRODUCT_SATURATE_EN to saturate the result.
module inner_product
  import inner_product_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4,
  parameter int F = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             s_stb,
  input  logic [N*W-1:0]           s_dat,
  output logic [N-1:0]             s_rdy,
  input  logic                     w_stb,
  input  logic [$clog2(N+1)-1:0]   w_adr,
  input  logic [W-1:0]             w_dat,
  output logic                     w_rdy,
  input  logic                     m_rdy,
  output logic                     m_stb,
  output logic [2*W-1:0]           m_dat
);

  localparam int A  = acc_width(W, N);
  localparam int AW = $clog2(N + 1);

  state_t              r_state;
  logic [N-1:0]        r_cap;
  logic signed [W-1:0] r_x [N];
  logic signed [A-1:0] r_acc;
  logic [AW-1:0]       r_idx;
  logic                r_m_stb;
  logic [2*W-1:0]      r_m_dat;

  logic [N-1:0]          w_hs;
  logic [N-1:0]          w_cap_next;
  logic                  w_we;
  logic signed [W-1:0]   w_wt_rd;
  logic signed [W-1:0]   w_bias;
  logic signed [W-1:0]   w_xsel;
  logic signed [2*W-1:0] w_prod;
  logic signed [A-1:0]   w_acc_next;
  logic [2*W-1:0]        w_conv;

  assign s_rdy      = (r_state == COLLECT) ? ~r_cap : '0;
  assign w_rdy      = (r_state == COLLECT);
  assign w_hs       = s_stb & s_rdy;
  assign w_cap_next = r_cap | w_hs;
  assign w_we       = w_stb & w_rdy;
  assign m_stb      = r_m_stb;
  assign m_dat      = r_m_dat;

  inner_weights #(.W(W), .N(N), .AW(AW)) u_weights (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_adr  (w_adr),
    .i_dat  (w_dat),
    .i_radr (r_idx),
    .o_rdat (w_wt_rd),
    .o_bias (w_bias)
  );

  always_comb begin
    w_xsel = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == AW'(i)) w_xsel = r_x[i];
    end
  end

  assign w_prod     = (2*W)'(w_wt_rd) * (2*W)'(w_xsel);
  assign w_acc_next = r_acc + A'(w_prod);

`ifdef INNER_PRODUCT_SATURATE_EN
  assign w_conv = (2*W)'(sat2w(longint'(w_acc_next), 2 * W));
`else
  assign w_conv = w_acc_next[2*W-1:0];
`endif

  // The final MAC term is folded into the output register so m_dat is valid as m_stb rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= COLLECT;
      r_cap   <= '0;
      for (int i = 0; i < N; i++) r_x[i] <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_m_stb <= 1'b0;
      r_m_dat <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          for (int i = 0; i < N; i++) begin
            if (w_hs[i]) r_x[i] <= s_dat[i*W +: W];
          end
          r_cap <= w_cap_next;
          if (&w_cap_next) begin
            r_state <= MAC;
            r_acc   <= A'(w_bias) <<< F;
            r_idx   <= '0;
          end
        end
        MAC: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + AW'(1);
          if (r_idx == AW'(N - 1)) begin
            r_state <= OUT;
            r_m_stb <= 1'b1;
            r_m_dat <= w_conv;
          end
        end
        OUT: begin
          if (m_rdy) begin
            r_state <= COLLECT;
            r_cap   <= '0;
            r_m_stb <= 1'b0;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_inner_product.sv
// Directed bench for inner_product (W=8, N=4, F=4) with hand-computed results.
module tb_inner_product;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     s_stb = '0;
  logic [N*W-1:0]   s_dat = '0;
  logic [N-1:0]     s_rdy;
  logic             w_stb = 1'b0;
  logic [AW-1:0]    w_adr = '0;
  logic [W-1:0]     w_dat = '0;
  logic             w_rdy;
  logic             m_rdy = 1'b0;
  logic             m_stb;
  logic [2*W-1:0]   m_dat;

  int n_checks = 0;
  int n_pass   = 0;

  inner_product #(.W(W), .N(N), .F(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_stb (s_stb),
    .s_dat (s_dat),
    .s_rdy (s_rdy),
    .w_stb (w_stb),
    .w_adr (w_adr),
    .w_dat (w_dat),
    .w_rdy (w_rdy),
    .m_rdy (m_rdy),
    .m_stb (m_stb),
    .m_dat (m_dat)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_weight(input logic [AW-1:0] adr, input logic [W-1:0] dat);
    w_stb = 1'b1;
    w_adr = adr;
    w_dat = dat;
    tick();
    w_stb = 1'b0;
  endtask

  task automatic send_all(input logic [N*W-1:0] dat);
    s_dat = dat;
    s_stb = '1;
    tick();
    s_stb = '0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (m_stb !== 1'b1 && cycles < 50) begin
      tick();
      cycles++;
    end
  endtask

  task automatic take_result;
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if (m_stb !== 1'b0) $display("FAIL reset_m_stb: got %b expected 0", m_stb); else n_pass++;
    n_checks++;
    if (m_dat !== 16'h0000) $display("FAIL reset_m_dat: got %h expected 0000", m_dat); else n_pass++;
    n_checks++;
    if (s_rdy !== 4'hF) $display("FAIL reset_s_rdy: got %b expected 1111", s_rdy); else n_pass++;
    n_checks++;
    if (w_rdy !== 1'b1) $display("FAIL reset_w_rdy: got %b expected 1", w_rdy); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_nominal;
    int c;
    for (int i = 0; i <= N; i++) write_weight(AW'(i), 8'h10);
    send_all({8'hF0, 8'h30, 8'h20, 8'h10});
    n_checks++;
    if (s_rdy !== 4'h0 || w_rdy !== 1'b0)
      $display("FAIL nominal_mac_rdy: got s_rdy=%b w_rdy=%b expected 0000/0", s_rdy, w_rdy);
    else n_pass++;
    wait_result(c);
    n_checks++;
    if (c !== 4) $display("FAIL nominal_latency: got %0d cycles expected 4", c); else n_pass++;
    n_checks++;
    if (m_dat !== 16'h0600) $display("FAIL nominal_dat: got %h expected 0600", m_dat); else n_pass++;
    take_result();
    n_checks++;
    if (m_stb !== 1'b0 || s_rdy !== 4'hF)
      $display("FAIL nominal_return: got m_stb=%b s_rdy=%b expected 0/1111", m_stb, s_rdy);
    else n_pass++;
  endtask

  task automatic test_out_of_order;
    int c;
    s_dat[3*W +: W] = 8'hF0;
    s_stb = 4'b1000;
    tick();
    n_checks++;
    if (s_rdy !== 4'b0111) $display("FAIL ooo_rdy_ch3: got %b expected 0111", s_rdy); else n_pass++;
    s_dat[3*W +: W] = 8'h7F;  // held strobe with new data must not be re-latched
    tick();
    s_dat[1*W +: W] = 8'h20;
    s_stb = 4'b1010;
    tick();
    n_checks++;
    if (s_rdy !== 4'b0101) $display("FAIL ooo_rdy_ch1: got %b expected 0101", s_rdy); else n_pass++;
    s_stb = 4'b1000;
    tick();
    s_dat[0 +: W] = 8'h10;
    s_stb = 4'b1001;
    tick();
    n_checks++;
    if (s_rdy !== 4'b0100) $display("FAIL ooo_rdy_ch0: got %b expected 0100", s_rdy); else n_pass++;
    s_stb = 4'b1000;
    tick();
    tick();
    n_checks++;
    if (m_stb !== 1'b0) $display("FAIL ooo_early_stb: got %b expected 0", m_stb); else n_pass++;
    s_dat[2*W +: W] = 8'h30;
    s_stb = 4'b1111;
    tick();
    s_stb = '0;
    wait_result(c);
    n_checks++;
    if (c !== 4) $display("FAIL ooo_latency: got %0d cycles expected 4", c); else n_pass++;
    n_checks++;
    if (m_dat !== 16'h0600) $display("FAIL ooo_dat: got %h expected 0600", m_dat); else n_pass++;
    take_result();
  endtask

  task automatic test_backpressure;
    int c;
    send_all({8'hF0, 8'h30, 8'h20, 8'h10});
    w_stb = 1'b1;
    w_adr = '0;
    w_dat = 8'h20;
    n_checks++;
    if (w_rdy !== 1'b0) $display("FAIL bp_mac_w_rdy: got %b expected 0", w_rdy); else n_pass++;
    wait_result(c);
    n_checks++;
    if (c !== 4) $display("FAIL bp_latency: got %0d cycles expected 4", c); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({m_stb, m_dat, s_rdy, w_rdy} !== {1'b1, 16'h0600, 4'h0, 1'b0})
        $display("FAIL bp_hold_%0d: got stb=%b dat=%h s_rdy=%b w_rdy=%b expected 1/0600/0000/0",
                 k, m_stb, m_dat, s_rdy, w_rdy);
      else n_pass++;
      tick();
    end
    take_result();
    n_checks++;
    if (w_rdy !== 1'b1 || m_stb !== 1'b0)
      $display("FAIL bp_collect: got w_rdy=%b m_stb=%b expected 1/0", w_rdy, m_stb);
    else n_pass++;
    tick();
    w_stb = 1'b0;
    send_all({8'hF0, 8'h30, 8'h20, 8'h10});
    wait_result(c);
    n_checks++;
    if (m_dat !== 16'h0700) $display("FAIL bp_next_dat: got %h expected 0700", m_dat); else n_pass++;
    take_result();
    write_weight(3'd0, 8'h10);
  endtask

  task automatic test_invalid_addr;
    int c;
    w_stb = 1'b1;
    w_adr = 3'd7;
    w_dat = 8'd99;
    n_checks++;
    if (w_rdy !== 1'b1) $display("FAIL inv_w_rdy: got %b expected 1", w_rdy); else n_pass++;
    tick();
    w_stb = 1'b0;
    send_all({8'hF0, 8'h30, 8'h20, 8'h10});
    wait_result(c);
    n_checks++;
    if (m_dat !== 16'h0600) $display("FAIL inv_dat: got %h expected 0600", m_dat); else n_pass++;
    take_result();
  endtask

  task automatic test_overflow;
    int c;
    logic [2*W-1:0] exp_dat;
`ifdef INNER_PRODUCT_SATURATE_EN
    exp_dat = 16'h7FFF;
`else
    exp_dat = 16'h03F4;
`endif
    for (int i = 0; i <= N; i++) write_weight(AW'(i), 8'h7F);
    send_all({4{8'h7F}});
    wait_result(c);
    n_checks++;
    if (m_dat !== exp_dat) $display("FAIL overflow_dat: got %h expected %h", m_dat, exp_dat); else n_pass++;
    take_result();
  endtask

  task automatic test_reset_mid_mac;
    int c;
    send_all({4{8'h10}});
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({m_stb, s_rdy, w_rdy} !== {1'b0, 4'hF, 1'b1})
      $display("FAIL rst_mac_outputs: got stb=%b s_rdy=%b w_rdy=%b expected 0/1111/1", m_stb, s_rdy, w_rdy);
    else n_pass++;
    n_checks++;
    if (m_dat !== 16'h0000) $display("FAIL rst_mac_dat: got %h expected 0000", m_dat); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    send_all({8'hF0, 8'h30, 8'h20, 8'h10});
    wait_result(c);
    n_checks++;
    if (c !== 4) $display("FAIL rst_fresh_latency: got %0d cycles expected 4", c); else n_pass++;
    n_checks++;
    if (m_dat !== 16'h0000) $display("FAIL rst_fresh_dat: got %h expected 0000", m_dat); else n_pass++;
    take_result();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_out_of_order();
    test_backpressure();
    test_invalid_addr();
    test_overflow();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
